// File: rtl/jtag_vpi_pkg.sv
// rtl/jtag_vpi_pkg.sv - shared encodings for the command-driven JTAG master
package jtag_vpi_pkg;

  typedef enum logic [1:0] {
    OP_RESET     = 2'd0,
    OP_TMS_SEQ   = 2'd1,
    OP_SCAN      = 2'd2,
    OP_SCAN_FLIP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Shifted LSB first: five 1s walk any TAP to Test-Logic-Reset, the 0 parks it in Run-Test/Idle.
  localparam logic [5:0] RESET_TMS_PATTERN = 6'b011111;
  localparam int         RESET_LEN         = 6;

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - half-period counter; strobes on the last clk_i of each tck phase
module jtag_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic phase_end_o
);

  localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(TCK_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_end_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || phase_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jtag_vpi_driver.sv
// rtl/jtag_vpi_driver.sv - valid/ready command port bit-banging tck/tms/tdi and capturing tdo
module jtag_vpi_driver
  import jtag_vpi_pkg::*;
#(
  parameter int TCK_HALF = 2,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable,
  input  logic              init_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d, cap_q, cap_d;
  logic              armed_q, armed_d, init_prev_q;
  logic              tms_hold_q, tms_hold_d, tdi_hold_q, tdi_hold_d;

  logic              running, phase_end, bit_val, last_bit, tms_bit, tdi_bit;
  logic [DATA_W-1:0] data_sh;
  logic [LEN_W-1:0]  len_clamped;

  assign running = (state_q == ST_LOW) || (state_q == ST_HIGH);

  jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .run_i       (running && enable),
    .phase_end_o (phase_end)
  );

  assign data_sh     = data_q >> idx_q;
  assign bit_val     = data_sh[0];
  assign last_bit    = (idx_q + LEN_W'(1)) == len_q;
  assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign cmd_ready   = (state_q == ST_IDLE) && armed_q && enable;

  always_comb begin
    tms_bit = 1'b0;
    tdi_bit = 1'b0;
    case (op_q)
      OP_RESET, OP_TMS_SEQ: tms_bit = bit_val;
      OP_SCAN:              tdi_bit = bit_val;
      default: begin
        tdi_bit = bit_val;
        tms_bit = last_bit;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    idx_d      = idx_q;
    data_d     = data_q;
    cap_d      = cap_q;
    armed_d    = armed_q | (init_prev_q & ~init_done);
    tms_hold_d = tms_hold_q;
    tdi_hold_d = tdi_hold_q;
    if (running) begin
      tms_hold_d = tms_bit;
      tdi_hold_d = tdi_bit;
    end
    // Disable aborts any command silently; armed survives so re-enable needs no new init pulse.
    if (!enable) begin
      state_d    = ST_IDLE;
      tms_hold_d = 1'b0;
      tdi_hold_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_d  = op_e'(cmd_op);
            idx_d = '0;
            cap_d = '0;
            if (op_e'(cmd_op) == OP_RESET) begin
              len_d   = LEN_W'(RESET_LEN);
              data_d  = DATA_W'(RESET_TMS_PATTERN);
              state_d = ST_LOW;
            end else begin
              len_d   = len_clamped;
              data_d  = cmd_data;
              state_d = (len_clamped == '0) ? ST_DONE : ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (phase_end) state_d = ST_HIGH;
        end
        ST_HIGH: begin
          if (phase_end) begin
            cap_d = cap_q | (DATA_W'(tdo) << idx_q);
            if (last_bit) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + LEN_W'(1);
              state_d = ST_LOW;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RESET;
      len_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      armed_q     <= 1'b0;
      init_prev_q <= 1'b0;
      tms_hold_q  <= 1'b0;
      tdi_hold_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      armed_q     <= armed_d;
      init_prev_q <= init_done;
      tms_hold_q  <= tms_hold_d;
      tdi_hold_q  <= tdi_hold_d;
    end
  end

  assign tck       = enable && (state_q == ST_HIGH);
  assign tms       = enable && (running ? tms_bit : tms_hold_q);
  assign tdi       = enable && (running ? tdi_bit : tdi_hold_q);
  assign rsp_valid = enable && (state_q == ST_DONE);
  assign rsp_data  = rsp_valid ? cap_q : '0;

endmodule

// File: tb/tb_jtag_vpi_driver.sv
// tb/tb_jtag_vpi_driver.sv - vector table, random commands vs reference model, abort/reset sequences
module tb_jtag_vpi_driver;

  localparam int TCK_HALF = 2;
  localparam int DATA_W   = 32;
  localparam int LEN_W    = 6;

  logic              clk = 1'b0;
  logic              rst_i, enable, init_done, cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data, rsp_data;
  logic              rsp_valid, tck, tms, tdi, tdo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtag_vpi_driver #(.TCK_HALF(TCK_HALF), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable(enable), .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    logic [31:0] tdo_pre;
    int          e_np;
    int          e_lat;
    logic [31:0] e_tms;
    logic [31:0] e_tdi;
    logic [31:0] e_rsp;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                           output bit ok);
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin
      step();
      w++;
    end
    ok = cmd_ready;
    if (!ok) return;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         input logic [31:0] tdo_pre, output bit ok, output int lat,
                         output logic [31:0] rsp, output logic [31:0] tms_s,
                         output logic [31:0] tdi_s, output int np);
    bit   acc;
    logic prev;
    ok = 0; lat = 0; rsp = '0; tms_s = '0; tdi_s = '0; np = 0;
    tdo = tdo_pre[0];
    start_cmd(op, len, data, acc);
    if (!acc) return;
    prev = 1'b0;
    lat  = 1;
    while (lat <= 300) begin
      if (tck && !prev && np < 32) begin
        tms_s[np] = tms;
        tdi_s[np] = tdi;
        tdo       = tdo_pre[np];
        np++;
      end
      prev = tck;
      if (rsp_valid) begin
        ok  = 1;
        rsp = rsp_data;
        return;
      end
      step();
      lat++;
    end
  endtask

  task automatic check_cmd(input string nm, input logic [1:0] op, input logic [5:0] len,
                           input logic [31:0] data, input logic [31:0] tdo_pre,
                           input int e_np, input int e_lat, input logic [31:0] e_tms,
                           input logic [31:0] e_tdi, input logic [31:0] e_rsp);
    bit ok;
    int lat, np;
    logic [31:0] rsp, tms_s, tdi_s;
    run_cmd(op, len, data, tdo_pre, ok, lat, rsp, tms_s, tdi_s, np);
    chk({nm, "_rsp_seen"}, 32'(ok), 32'd1);
    chk({nm, "_latency"}, lat, e_lat);
    chk({nm, "_pulses"}, np, e_np);
    chk({nm, "_tms"}, tms_s, e_tms);
    chk({nm, "_tdi"}, tdi_s, e_tdi);
    chk({nm, "_rsp_data"}, rsp, e_rsp);
  endtask

  // Expected behaviour derived straight from the command semantics.
  task automatic model(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                       input logic [31:0] tdo_pre, output int n, output int lat,
                       output logic [31:0] e_tms, output logic [31:0] e_tdi,
                       output logic [31:0] e_rsp);
    logic [31:0] pat;
    pat = 32'b011111;
    e_tms = '0; e_tdi = '0; e_rsp = '0;
    if (op == 2'd0) n = 6;
    else n = (int'(len) > 32) ? 32 : int'(len);
    for (int k = 0; k < n; k++) begin
      case (op)
        2'd0: e_tms[k] = pat[k];
        2'd1: e_tms[k] = data[k];
        2'd2: e_tdi[k] = data[k];
        default: begin
          e_tdi[k] = data[k];
          e_tms[k] = (k == n - 1);
        end
      endcase
      e_rsp[k] = tdo_pre[k];
    end
    lat = 1 + n * 2 * TCK_HALF;
  endtask

  initial begin
    bit ok;
    int np, n, lat, cnt;
    logic prev;
    logic [1:0]  r_op;
    logic [5:0]  r_len;
    logic [31:0] r_data, r_tdo, e_tms, e_tdi, e_rsp;

    vecs[0] = '{"reset_op",   2'd0, 6'd0,  32'hFFFF_FFFF, 32'h0,         6,   25,  32'h1F, 32'h0,         32'h0};
    vecs[1] = '{"scan8",      2'd2, 6'd8,  32'hA5,        32'h3C,        8,   33,  32'h0,  32'hA5,        32'h3C};
    vecs[2] = '{"flip4",      2'd3, 6'd4,  32'hF,         32'h5,         4,   17,  32'h8,  32'hF,         32'h5};
    vecs[3] = '{"tms3",       2'd1, 6'd3,  32'h6,         32'hFF,        3,   13,  32'h6,  32'h0,         32'h7};
    vecs[4] = '{"tms_len0",   2'd1, 6'd0,  32'hFF,        32'hFF,        0,   1,   32'h0,  32'h0,         32'h0};
    vecs[5] = '{"scan_clamp", 2'd2, 6'd40, 32'hDEAD_BEEF, 32'h1234_5678, 32,  129, 32'h0,  32'hDEAD_BEEF, 32'h1234_5678};
    vecs[6] = '{"flip1",      2'd3, 6'd1,  32'h0,         32'h1,         1,   5,   32'h1,  32'h0,         32'h1};

    rst_i = 1'b1; enable = 1'b1; init_done = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_len = '0; cmd_data = '0; tdo = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    step();
    chk("reset_tck", tck, 0);
    chk("reset_tms", tms, 0);
    chk("reset_tdi", tdi, 0);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);

    repeat (5) step();
    chk("unarmed_cmd_ready", cmd_ready, 0);
    init_done = 1'b1;
    step();
    chk("init_high_cmd_ready", cmd_ready, 0);
    init_done = 1'b0;
    step();
    chk("armed_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 7; i++)
      check_cmd(vecs[i].name, vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].tdo_pre,
                vecs[i].e_np, vecs[i].e_lat, vecs[i].e_tms, vecs[i].e_tdi, vecs[i].e_rsp);

    // Pins hold their last driven levels between commands.
    check_cmd("tms_last1", 2'd1, 6'd1, 32'h1, 32'h0, 1, 5, 32'h1, 32'h0, 32'h0);
    repeat (2) step();
    chk("hold_tms", tms, 1);
    chk("hold_tck", tck, 0);
    check_cmd("scan_last1", 2'd2, 6'd2, 32'h2, 32'h0, 2, 9, 32'h0, 32'h2, 32'h0);
    repeat (2) step();
    chk("hold_tdi", tdi, 1);
    chk("hold_tms0", tms, 0);

    for (int i = 0; i < 20; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_len  = 6'($urandom_range(0, 40));
      r_data = $urandom;
      r_tdo  = $urandom;
      model(r_op, r_len, r_data, r_tdo, n, lat, e_tms, e_tdi, e_rsp);
      check_cmd($sformatf("rand%0d", i), r_op, r_len, r_data, r_tdo, n, lat, e_tms, e_tdi, e_rsp);
    end

    // Abort during the HIGH phase of bit 3.
    start_cmd(2'd2, 6'd8, 32'hFF, ok);
    chk("abort_accept", 32'(ok), 1);
    np = 0; prev = 1'b0; cnt = 0;
    while (cnt < 100) begin
      if (tck && !prev) np++;
      if (np == 4) break;
      prev = tck;
      step();
      cnt++;
    end
    chk("abort_reached_bit3", np, 4);
    enable = 1'b0;
    step();
    chk("abort_tck", tck, 0);
    chk("abort_tms", tms, 0);
    chk("abort_tdi", tdi, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid) cnt++;
      step();
    end
    chk("abort_no_rsp", cnt, 0);
    enable = 1'b1;
    step();
    chk("reenable_cmd_ready", cmd_ready, 1);
    check_cmd("after_abort", 2'd2, 6'd8, 32'hA5, 32'h3C, 8, 33, 32'h0, 32'hA5, 32'h3C);

    // Reset mid-command returns everything to reset values and disarms.
    start_cmd(2'd2, 6'd8, 32'hFF, ok);
    repeat (3) step();
    rst_i = 1'b1;
    step();
    chk("midrst_tck", tck, 0);
    chk("midrst_tdi", tdi, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    rst_i = 1'b0;
    repeat (3) step();
    chk("midrst_disarmed", cmd_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_vpi_driver.md
Name: jtag_vpi_driver

Overview:
- Command-driven JTAG master that bit-bangs tck/tms/tdi toward a target TAP and captures tdo.
- Sits between a host-side command source (a simulation socket bridge or debug controller) and the SoC JTAG pads (tms/tck/tdi/tdo).
- Stays idle until the target leaves reset and the driver is enabled.
- Replaces the VPI socket with a valid/ready command port and a response strobe.

Parameters:
- TCK_HALF, 2, clk_i cycles per tck half-period (≥1).
- DATA_W, 32, max bits per scan command.
- LEN_W, 6, width of cmd_len (must hold DATA_W).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- enable  in  1  driver enable; 0 = outputs forced 0, no commands accepted
- init_done  in  1  target reset indicator; driver arms on its 1→0 transition
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_op  in  2  0=RESET, 1=TMS_SEQ, 2=SCAN, 3=SCAN_FLIP_TMS
- cmd_len  in  LEN_W  bit count (ignored for RESET)
- cmd_data  in  DATA_W  TMS bits (TMS_SEQ) or TDI bits (SCAN*), LSB first
- rsp_valid  out  1  one-cycle pulse, command complete
- rsp_data  out  DATA_W  captured tdo bits, bit i = bit i shifted
- tck  out  1  JTAG clock
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data in
- tdo  in  1  JTAG data out

Behaviour:
- Reset: tck=tms=tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, armed=0, state IDLE.
- armed: set when init_done is sampled 0 after having been sampled 1 on the previous clk_i; sticky; cleared only by rst_i.
- cmd_ready=1 only in IDLE with armed=1 and enable=1.
- States: IDLE, LOW, HIGH, DONE.
- IDLE→LOW on accept:
  - Latch op, length and data.
  - Bit index := 0.
  - RESET loads 6 bits with TMS pattern 0b011111 (five 1s, then 0), TDI=0.
- LOW (TCK_HALF cycles): tck=0; tms/tdi driven from current bit for the whole phase.
  - TMS_SEQ: tms=cmd_data[i], tdi=0.
  - SCAN: tdi=cmd_data[i], tms=0.
  - SCAN_FLIP_TMS: as SCAN, except tms=1 on the last bit.
- HIGH (TCK_HALF cycles): tck=1.
  - tdo sampled into capture[i] on the last clk_i of HIGH.
  - Then i+1 < len → LOW; else → DONE.
- DONE (1 cycle): rsp_valid=1, rsp_data=capture (bits ≥len are 0); → IDLE.
- Latency, accept to rsp_valid: 1 + len·2·TCK_HALF cycles. RESET uses len=6.
- len=0 on non-RESET op: no tck pulses; next cycle DONE with rsp_data=0.
- len>DATA_W: clamped to DATA_W.
- Between commands: tck=0; tms/tdi hold last driven values.
- enable deasserted mid-command:
  - Abort to IDLE next cycle, no rsp_valid.
  - tck/tms/tdi forced 0 while enable=0.
  - armed is kept.
- rst_i mid-command: immediate return to reset values.
- No back-to-back acceptance: cmd_ready is 0 in DONE.

Decomposition:
- Shared package jtag_vpi_pkg: op encodings (OP_RESET, OP_TMS_SEQ, OP_SCAN, OP_SCAN_FLIP), RESET_TMS_PATTERN=6'b011111, RESET_LEN=6.
- One natural sub-module, jtag_tck_gen: half-period counter producing phase-end strobes.
- Everything else lives in the top FSM.

Test Plan:
- Arming: init_done 0 after reset → cmd_ready stays 0. Pulse init_done 1→0 → cmd_ready=1 on the following cycle.
- RESET op, TCK_HALF=2 → 6 tck pulses with tms sequence 1,1,1,1,1,0; rsp_valid exactly 25 cycles after accept; rsp_data=0.
- SCAN len=8, cmd_data=0xA5, tdo tied to a bench shift register preloaded 0x3C:
  - tdi stream 1,0,1,0,0,1,0,1.
  - tms=0 throughout.
  - rsp_data=0x3C.
- SCAN_FLIP_TMS len=4, data=0xF → tms=0,0,0,1 across the four tck pulses; tdi=1 on every pulse.
- TMS_SEQ len=3, data=0b110 → tms 0,1,1; tdi=0; then len=0 TMS_SEQ → rsp_valid 1 cycle after accept, no tck edge.
- Abort: drop enable during the bit-3 HIGH phase of a len-8 SCAN → tck/tms/tdi=0 next cycle, no rsp_valid. Re-enable → cmd_ready=1 and a new command completes normally.
